// File: rtl/scu_pkg.sv
// Shared definitions for the servo control unit host interface:
// command/status word layout, command encodings and bridge FSM states.
package scu_pkg;

  localparam int unsigned CMD_WIDTH    = 32;
  localparam int unsigned STATUS_WIDTH = 32;

  // inputR (command word) field layout
  localparam int unsigned IN_ANGLE_LSB = 0;
  localparam int unsigned IN_ANGLE_W   = 12;
  localparam int unsigned IN_PWM_LSB   = 12;
  localparam int unsigned IN_PWM_W     = 8;
  localparam int unsigned IN_MODE_LSB  = 27;
  localparam int unsigned IN_MODE_W    = 2;
  localparam int unsigned IN_CMD_LSB   = 29;
  localparam int unsigned IN_CMD_W     = 2;
  localparam int unsigned IN_PWR_BIT   = 31;

  // statusR is consumed as an opaque word by the bridge
  localparam int unsigned ST_LSB = 0;
  localparam int unsigned ST_W   = STATUS_WIDTH;

  typedef enum logic [1:0] {
    CMD_RUN       = 2'd0,
    CMD_RESET     = 2'd1,
    CMD_BRAKE     = 2'd2,
    CMD_BRAKE_ALT = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    MODE_BANG = 2'd0,
    MODE_PROP = 2'd1
  } mode_e;

  // Power off, command = brake, every other field zero
  localparam logic [CMD_WIDTH-1:0] RESET_CMD = {1'b0, CMD_BRAKE, 29'd0};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/spi_cmd_bridge_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, followed by one
// history flop that yields single-cycle rise/fall pulses.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Free-running chain and history flop: keeping them out of reset means a
  // line already low when reset releases produces no edge afterwards.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], async_i};
    prev_q <= sync_q[STAGES-1];
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_cmd_bridge.sv
// SPI mode-0 slave: shifts a command word in on MOSI while the status
// snapshot shifts out on MISO; commits the command only on a clean frame.
module spi_cmd_bridge #(
  parameter int unsigned            FRAME_BITS  = 32,
  parameter int unsigned            SYNC_STAGES = 2,
  parameter logic [FRAME_BITS-1:0]  RESET_CMD   = scu_pkg::RESET_CMD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  csN,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  misoEn,
  input  logic [FRAME_BITS-1:0] statusR,
  output logic [FRAME_BITS-1:0] inputR,
  output logic                  cmdValid,
  output logic                  frameErr
);

  import scu_pkg::*;

  localparam logic [5:0] FRAME_CNT = 6'(FRAME_BITS);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .async_i (sclk),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk     (clk),
    .async_i (csN),
    .level_o (cs_level_unused),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk     (clk),
    .async_i (mosi),
    .level_o (mosi_s),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  bridge_state_e         state_q;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [5:0]            cnt_q, cnt_d;
  logic                  overrun_q;
  logic                  pend_q;

  // Next values of the shift registers and the saturating bit counter
  always_comb begin
    rx_d  = {rx_q[FRAME_BITS-2:0], mosi_s};
    tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 6'd1;
  end

  // Frame FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      inputR    <= RESET_CMD;
      miso      <= 1'b0;
      misoEn    <= 1'b0;
      cmdValid  <= 1'b0;
      frameErr  <= 1'b0;
      rx_q      <= '0;
      tx_q      <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      cmdValid <= 1'b0;
      frameErr <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cs_fall || pend_q) begin
            rx_q      <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            tx_q      <= statusR;
            miso      <= statusR[FRAME_BITS-1];
            misoEn    <= 1'b1;
            pend_q    <= 1'b0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          // csN rise wins over any sclk edge seen in the same cycle
          if (cs_rise) begin
            state_q <= COMMIT;
          end else begin
            if (sclk_rise) begin
              rx_q  <= rx_d;
              cnt_q <= cnt_d;
              if (cnt_d > FRAME_CNT) overrun_q <= 1'b1;
            end
            if (sclk_fall) begin
              tx_q <= tx_d;
              miso <= tx_d[FRAME_BITS-1];
            end
          end
        end
        COMMIT: begin
          misoEn <= 1'b0;
          miso   <= 1'b0;
          if (cnt_q == FRAME_CNT && !overrun_q) begin
            inputR   <= rx_q;
            cmdValid <= 1'b1;
          end else begin
            frameErr <= 1'b1;
          end
          // A csN fall seen here is a one-cycle pulse; hold it for IDLE
          pend_q  <= cs_fall;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
